// File: rtl/maquina_pkg.sv
// Shared constants for the parametrised switch control FSM.
// One-hot state encodings and default parameter values.
package maquina_pkg;

    localparam int ST_W = 5;

    localparam logic [ST_W-1:0] ST_RESET  = 5'b00001;
    localparam logic [ST_W-1:0] ST_INIT   = 5'b00010;
    localparam logic [ST_W-1:0] ST_IDLE   = 5'b00100;
    localparam logic [ST_W-1:0] ST_ACTIVE = 5'b01000;
    localparam logic [ST_W-1:0] ST_ERROR  = 5'b10000;

    localparam int NUM_FIFOS_DEF = 5;
    localparam int UMB_W_DEF     = 2;
    localparam int IDLE_DLY_DEF  = 4;
    localparam int ERR_CNT_W_DEF = 8;

    typedef enum logic [ST_W-1:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_t;

endpackage

// File: rtl/maquina_idle_cnt.sv
// Saturating consecutive-cycle counter with clear and hit output.
// hit fires on the DLY-th consecutive enabled cycle.
module maquina_idle_cnt #(
    parameter int DLY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(DLY + 1);
    localparam logic [CW-1:0] LIM    = CW'(DLY);
    localparam logic [CW-1:0] HIT_AT = CW'(DLY - 1);

    logic [CW-1:0] cnt;

    assign hit = en && (cnt >= HIT_AT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIM) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/maquina_ctrl_param.sv
// Switch control FSM: RESET/INIT/IDLE/ACTIVE/ERROR sequencing,
// threshold capture, masked sticky errors and error-entry count.
module maquina_ctrl_param
    import maquina_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int UMB_W     = UMB_W_DEF,
    parameter int IDLE_DLY  = IDLE_DLY_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 err_clr,
    input  logic [UMB_W-1:0]     Umbrales_MFs,
    input  logic [UMB_W-1:0]     Umbrales_VCs,
    input  logic [UMB_W-1:0]     Umbrales_Ds,
    input  logic [NUM_FIFOS-1:0] FIFO_empties,
    input  logic [NUM_FIFOS-1:0] FIFO_errors,
    input  logic [NUM_FIFOS-1:0] err_mask,
    output logic [UMB_W-1:0]     Umbrales_MFs_internos,
    output logic [UMB_W-1:0]     Umbrales_VCs_internos,
    output logic [UMB_W-1:0]     Umbrales_Ds_internos,
    output logic                 error_out,
    output logic [NUM_FIFOS-1:0] errors_out,
    output logic                 active_out,
    output logic                 idle_out,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_FIFOS-1:0] merr;
    logic [NUM_FIFOS-1:0] sticky_nxt;
    logic                 all_empty;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic                 cnt_hit;

    assign merr      = FIFO_errors & ~err_mask;
    assign all_empty = &FIFO_empties;
    assign cnt_en    = (state == S_ACTIVE) && all_empty;
    assign cnt_clr   = (state_nxt != S_ACTIVE) || !all_empty;

    maquina_idle_cnt #(
        .DLY (IDLE_DLY)
    ) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .hit   (cnt_hit)
    );

    always_comb begin
        state_nxt = S_RESET;
        case (state)
            S_RESET:  state_nxt = S_INIT;
            S_INIT:   state_nxt = init ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (init)            state_nxt = S_INIT;
                else if (|merr)      state_nxt = S_ERROR;
                else if (!all_empty) state_nxt = S_ACTIVE;
                else                 state_nxt = S_IDLE;
            end
            S_ACTIVE: begin
                if (init)         state_nxt = S_INIT;
                else if (|merr)   state_nxt = S_ERROR;
                else if (cnt_hit) state_nxt = S_IDLE;
                else              state_nxt = S_ACTIVE;
            end
            S_ERROR:  state_nxt = err_clr ? S_RESET : S_ERROR;
            default:  state_nxt = S_RESET;
        endcase
    end

    // errors_out doubles as the sticky register; it is zero outside ERROR
    always_comb begin
        sticky_nxt = '0;
        if (state == S_ERROR) begin
            if (!err_clr) sticky_nxt = errors_out | merr;
        end else if (state_nxt == S_ERROR) begin
            sticky_nxt = merr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= S_RESET;
            idle_out              <= 1'b0;
            active_out            <= 1'b0;
            error_out             <= 1'b0;
            errors_out            <= '0;
            err_count             <= '0;
            Umbrales_MFs_internos <= '0;
            Umbrales_VCs_internos <= '0;
            Umbrales_Ds_internos  <= '0;
        end else begin
            state      <= state_nxt;
            idle_out   <= (state_nxt == S_IDLE);
            active_out <= (state_nxt == S_ACTIVE);
            error_out  <= (state_nxt == S_ERROR);
            errors_out <= sticky_nxt;
            if (state == S_INIT) begin
                Umbrales_MFs_internos <= Umbrales_MFs;
                Umbrales_VCs_internos <= Umbrales_VCs;
                Umbrales_Ds_internos  <= Umbrales_Ds;
            end
            if (state != S_ERROR && state_nxt == S_ERROR
                && err_count != '1) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_maquina_ctrl_param.sv
// Directed bench for maquina_ctrl_param (default build plus a
// 2-bit error counter build sharing the same stimulus).
module tb_maquina_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic       err_clr = 1'b0;
    logic [1:0] mf = '0;
    logic [1:0] vc = '0;
    logic [1:0] d = '0;
    logic [4:0] empties = '1;
    logic [4:0] errors = '0;
    logic [4:0] mask = '0;

    logic [1:0] mf_o, vc_o, d_o;
    logic       err_o, act_o, idle_o;
    logic [4:0] errs_o;
    logic [7:0] cnt_o;

    logic [1:0] mf_2, vc_2, d_2;
    logic       err_2, act_2, idle_2;
    logic [4:0] errs_2;
    logic [1:0] cnt_2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maquina_ctrl_param u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .init                  (init),
        .err_clr               (err_clr),
        .Umbrales_MFs          (mf),
        .Umbrales_VCs          (vc),
        .Umbrales_Ds           (d),
        .FIFO_empties          (empties),
        .FIFO_errors           (errors),
        .err_mask              (mask),
        .Umbrales_MFs_internos (mf_o),
        .Umbrales_VCs_internos (vc_o),
        .Umbrales_Ds_internos  (d_o),
        .error_out             (err_o),
        .errors_out            (errs_o),
        .active_out            (act_o),
        .idle_out              (idle_o),
        .err_count             (cnt_o)
    );

    maquina_ctrl_param #(
        .ERR_CNT_W (2)
    ) u_dut2 (
        .clk                   (clk),
        .reset                 (reset),
        .init                  (init),
        .err_clr               (err_clr),
        .Umbrales_MFs          (mf),
        .Umbrales_VCs          (vc),
        .Umbrales_Ds           (d),
        .FIFO_empties          (empties),
        .FIFO_errors           (errors),
        .err_mask              (mask),
        .Umbrales_MFs_internos (mf_2),
        .Umbrales_VCs_internos (vc_2),
        .Umbrales_Ds_internos  (d_2),
        .error_out             (err_2),
        .errors_out            (errs_2),
        .active_out            (act_2),
        .idle_out              (idle_2),
        .err_count             (cnt_2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({idle_o, act_o, err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status got %b want 000",
                     {idle_o, act_o, err_o});
        end
        n_checks++;
        if ({mf_o, vc_o, d_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_thr got %b want 0",
                     {mf_o, vc_o, d_o});
        end
        n_checks++;
        if (errs_o !== 5'b0 || cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err got %b/%0d want 0/0",
                     errs_o, cnt_o);
        end
    endtask

    task automatic test_init();
        init = 1'b1;
        mf = 2'b01;
        vc = 2'b10;
        d = 2'b11;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({mf_o, vc_o, d_o} !== 6'b0 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_entry got thr=%b idle=%b want 0/0",
                     {mf_o, vc_o, d_o}, idle_o);
        end
        tick();
        n_checks++;
        if ({mf_o, vc_o, d_o} !== 6'b01_10_11) begin
            n_fail++;
            $display("FAIL init_thr got %b want 011011",
                     {mf_o, vc_o, d_o});
        end
        tick();
        init = 1'b0;
        tick();
        n_checks++;
        if (idle_o !== 1'b1 || act_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_idle got idle=%b act=%b want 1/0",
                     idle_o, act_o);
        end
        mf = 2'b00;
        vc = 2'b00;
        d = 2'b00;
        tick();
        n_checks++;
        if ({mf_o, vc_o, d_o} !== 6'b01_10_11) begin
            n_fail++;
            $display("FAIL thr_hold got %b want 011011",
                     {mf_o, vc_o, d_o});
        end
    endtask

    task automatic test_active_hyst();
        empties = 5'b11110;
        tick();
        n_checks++;
        if (act_o !== 1'b1 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL go_active got act=%b idle=%b want 1/0",
                     act_o, idle_o);
        end
        empties = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (act_o !== 1'b1) begin
                n_fail++;
                $display("FAIL hyst_a%0d got act=%b want 1", i, act_o);
            end
        end
        empties = 5'b11101;
        tick();
        empties = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (act_o !== 1'b1 || idle_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hyst_b%0d got act=%b want 1", i, act_o);
            end
        end
        tick();
        n_checks++;
        if (idle_o !== 1'b1 || act_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hyst_idle got idle=%b act=%b want 1/0",
                     idle_o, act_o);
        end
    endtask

    task automatic test_error_mask();
        empties = 5'b11110;
        tick();
        mask = 5'b00100;
        errors = 5'b00100;
        tick();
        n_checks++;
        if (act_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL masked got act=%b err=%b want 1/0",
                     act_o, err_o);
        end
        errors = 5'b01000;
        tick();
        n_checks++;
        if (err_o !== 1'b1 || act_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_entry got err=%b act=%b want 1/0",
                     err_o, act_o);
        end
        n_checks++;
        if (errs_o !== 5'b01000 || cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL err_bits got %b/%0d want 01000/1",
                     errs_o, cnt_o);
        end
    endtask

    task automatic test_error_sticky_clr();
        errors = 5'b00001;
        tick();
        n_checks++;
        if (errs_o !== 5'b01001) begin
            n_fail++;
            $display("FAIL sticky_or got %b want 01001", errs_o);
        end
        errors = 5'b00000;
        tick();
        n_checks++;
        if (errs_o !== 5'b01001) begin
            n_fail++;
            $display("FAIL sticky_hold got %b want 01001", errs_o);
        end
        init = 1'b1;
        tick();
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL init_ignored got err=%b want 1", err_o);
        end
        init = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_o !== 1'b0 || errs_o !== 5'b0) begin
            n_fail++;
            $display("FAIL err_clr got err=%b bits=%b want 0/0",
                     err_o, errs_o);
        end
        tick();
        tick();
        n_checks++;
        if (idle_o !== 1'b1 || cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL after_clr got idle=%b cnt=%0d want 1/1",
                     idle_o, cnt_o);
        end
    endtask

    task automatic test_err_cnt_sat();
        logic [1:0] exp2;
        reset = 1'b0;
        mask = 5'b0;
        errors = 5'b0;
        empties = 5'b11111;
        tick();
        reset = 1'b1;
        tick();
        tick();
        for (int i = 1; i <= 5; i++) begin
            exp2 = (i > 3) ? 2'd3 : 2'(i);
            errors = 5'b00010;
            tick();
            n_checks++;
            if (err_o !== 1'b1 || cnt_o !== 8'(i)) begin
                n_fail++;
                $display("FAIL cnt8_%0d got err=%b cnt=%0d want 1/%0d",
                         i, err_o, cnt_o, i);
            end
            n_checks++;
            if (cnt_2 !== exp2) begin
                n_fail++;
                $display("FAIL cnt2_%0d got %0d want %0d",
                         i, cnt_2, exp2);
            end
            errors = 5'b0;
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_async_reset();
        empties = 5'b11110;
        tick();
        n_checks++;
        if (act_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async got act=%b want 1", act_o);
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({idle_o, act_o, err_o} !== 3'b000
            || cnt_o !== 8'd0 || {mf_o, vc_o, d_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_rst got st=%b cnt=%0d thr=%b want 0",
                     {idle_o, act_o, err_o}, cnt_o, {mf_o, vc_o, d_o});
        end
        mf = 2'b10;
        vc = 2'b01;
        d = 2'b11;
        empties = 5'b11111;
        #10;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({idle_o, act_o, err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_init got st=%b want 000",
                     {idle_o, act_o, err_o});
        end
        tick();
        n_checks++;
        if (idle_o !== 1'b1 || {mf_o, vc_o, d_o} !== 6'b10_01_11) begin
            n_fail++;
            $display("FAIL rst_resume got idle=%b thr=%b want 1/100111",
                     idle_o, {mf_o, vc_o, d_o});
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_active_hyst();
        test_error_mask();
        test_error_sticky_clr();
        test_err_cnt_sat();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maquina_ctrl_param.md
Name: maquina_ctrl_param

Overview:
- Parametrised successor to the switch control FSM.
- Sequences RESET/INIT/IDLE/ACTIVE/ERROR and captures the three FIFO threshold groups (MF, VC, D) during INIT.
- Reports idle, active and error status for N FIFOs.
- Adds over the previous generation:
  - per-channel error masking
  - sticky error accumulation
  - explicit error clear
  - IDLE hysteresis on return from ACTIVE
  - a saturating error-entry counter

Parameters:
NUM_FIFOS, 5, number of monitored FIFOs (empty/error bit width)
UMB_W, 2, width of each threshold field
IDLE_DLY, 4, consecutive all-empty cycles required for ACTIVE->IDLE (>=1)
ERR_CNT_W, 8, width of saturating error-entry counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
init  in  1  request (re)initialisation / threshold capture
err_clr  in  1  clear sticky errors, leave ERROR
Umbrales_MFs  in  UMB_W  MF threshold config
Umbrales_VCs  in  UMB_W  VC threshold config
Umbrales_Ds  in  UMB_W  D threshold config
FIFO_empties  in  NUM_FIFOS  per-FIFO empty flags
FIFO_errors  in  NUM_FIFOS  per-FIFO error flags
err_mask  in  NUM_FIFOS  1 = ignore that FIFO's error
Umbrales_MFs_internos  out  UMB_W  captured MF threshold
Umbrales_VCs_internos  out  UMB_W  captured VC threshold
Umbrales_Ds_internos  out  UMB_W  captured D threshold
error_out  out  1  high while in ERROR
errors_out  out  NUM_FIFOS  sticky masked errors, valid in ERROR, else 0
active_out  out  1  high while in ACTIVE
idle_out  out  1  high while in IDLE
err_count  out  ERR_CNT_W  number of ERROR entries, saturating

Behaviour:
- Reset: asynchronous, active-low; reset is named reset and clk is the single clock.
  - reset=0 forces state=RESET; all outputs 0; sticky errors, idle counter and err_count cleared.
  - Deassertion takes effect on the next rising clk.
- State encoding: one-hot, 5 bits: RESET=1, INIT=2, IDLE=4, ACTIVE=8, ERROR=16.
  - Any illegal encoding -> RESET on the next cycle.
- Output timing:
  - Status outputs are registered from the next-state decode, so they align exactly with the state register (no extra cycle of lag).
  - Thresholds are registered.
- Effective error term: merr = FIFO_errors & ~err_mask.
- RESET: -> INIT unconditionally.
- INIT:
  - Thresholds are loaded from the inputs every cycle in INIT.
  - init=1 keeps the FSM in INIT; init=0 -> IDLE.
  - Thresholds hold their value outside INIT.
- IDLE (idle_out=1), priority order:
  - init=1 -> INIT
  - else merr!=0 -> ERROR
  - else FIFO_empties != all-ones -> ACTIVE
- ACTIVE (active_out=1):
  - init=1 -> INIT
  - else merr!=0 -> ERROR
  - Idle counter: increments while FIFO_empties is all-ones and clears on any non-empty.
  - -> IDLE when the counter reaches IDLE_DLY; the counter clears on that transition.
  - IDLE_DLY=1 gives the previous generation's immediate behaviour.
- ERROR (error_out=1):
  - On entry, sticky is loaded with the merr that caused the transition.
  - While in ERROR, sticky |= merr every cycle.
  - errors_out = sticky; it is valid in the first ERROR cycle.
  - init is ignored in ERROR.
  - err_clr=1 -> RESET, and sticky clears on that edge.
  - err_clr has no effect in any other state.
- err_count:
  - Increments by 1 on each transition into ERROR.
  - Saturates at 2^ERR_CNT_W-1.
  - Cleared only by reset.
- Simultaneous events:
  - init beats error, and error beats activity.
  - An error in the same cycle as the idle counter expiring goes to ERROR.
- Mask change mid-ERROR: bits already captured in sticky remain set.

Decomposition:
- Shared package maquina_pkg holds:
  - state one-hot localparams ST_RESET..ST_ERROR
  - the state-width constant (5)
  - default parameter values
- One natural sub-module: maquina_idle_cnt, a parametrised saturating consecutive-cycle counter with clear/hit output.
  - Instantiated for the ACTIVE->IDLE hysteresis.
  - Reusable later for watchdogs.

Test Plan:
- Reset, then init=1 for 3 cycles with MF=2'b01, VC=2'b10, D=2'b11, then init=0 -> thresholds 01/10/11 one cycle after entry; idle_out=1 from the cycle after init falls.
- In IDLE, FIFO_empties=5'b11110 -> active_out=1 next cycle. Then all-ones for 3 cycles, one non-empty, then all-ones for 4 cycles -> IDLE entered exactly at the 4th consecutive empty (IDLE_DLY=4).
- In ACTIVE, err_mask=5'b00100, FIFO_errors=5'b00100 -> stays ACTIVE. Then FIFO_errors=5'b01000 -> error_out=1, errors_out=5'b01000, err_count=1.
- In ERROR, FIFO_errors=5'b00001 for 1 cycle -> errors_out=5'b01001, held. init=1 -> stays ERROR. err_clr=1 -> RESET then INIT, errors_out=0.
- ERR_CNT_W=2 build: 5 error/clear cycles -> err_count reads 1, 2, 3, 3, 3.
- Assert reset asynchronously mid-ACTIVE, off-edge -> all outputs 0 immediately, state RESET; after release, RESET->INIT sequence resumes.
